// File: rtl/ibex_secure_ex_seq.sv
// Masked multi-cycle secure execution sequencer (ALU ops on XOR-masked operands, N key slots).
// Latency: OpLatency+1 cycles accept-to-response; error responses after 1 cycle.
// Backpressure: one op in flight; req_ready_o only in IDLE; response held until rsp_ready_i.
module ibex_secure_ex_seq #(
    parameter int Width       = 32,
    parameter int NumKeySlots = 4,
    parameter int KeyWidth    = 128,
    parameter int OpLatency   = 4,
    localparam int SlotW      = (NumKeySlots > 1) ? $clog2(NumKeySlots) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   key_wr_i,
    input  logic [SlotW-1:0]       key_slot_i,
    input  logic [KeyWidth-1:0]    key_i,
    input  logic                   key_clr_i,
    output logic [NumKeySlots-1:0] key_valid_o,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [2:0]             req_op_i,
    input  logic [SlotW-1:0]       req_slot_i,
    input  logic [Width-1:0]       operand_a_i,
    input  logic [Width-1:0]       operand_b_i,
    input  logic                   flush_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [Width-1:0]       result_o,
    output logic                   error_o,
    output logic                   busy_o
);
    localparam int CntW     = (OpLatency > 1) ? $clog2(OpLatency) : 1;
    localparam int ShW      = $clog2(Width);
    localparam int NumWords = KeyWidth / Width;
    localparam logic [Width-1:0] LfsrTaps = Width'(32'h8020_0003);
    localparam logic [Width-1:0] LfsrSeed = Width'(32'hACE1_2468);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_SLL  = 3'd5;
    localparam logic [2:0] OP_SRL  = 3'd6;
    localparam logic [2:0] OP_SLTU = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [KeyWidth-1:0]    key_q [NumKeySlots];
    logic [NumKeySlots-1:0] key_valid_q;
    logic [KeyWidth-1:0]    sel_key;
    logic                   sel_valid;
    logic [Width-1:0]       key_fold;
    logic [Width-1:0]       mask;
    logic [Width-1:0]       lfsr_q;
    logic [Width-1:0]       lfsr_next;
    logic [Width-1:0]       mask_q;
    logic [Width-1:0]       a_q;
    logic [Width-1:0]       b_q;
    logic [Width-1:0]       res_q;
    logic [2:0]             op_q;
    logic                   err_q;
    logic [CntW-1:0]        cnt_q;
    logic                   accept;
    logic [Width-1:0]       op_a;
    logic [Width-1:0]       op_b;
    logic [ShW-1:0]         shamt;
    logic [Width-1:0]       alu_res;

    // Key slot storage; clear beats write, writes allowed in any state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumKeySlots; i++) key_q[i] <= '0;
            key_valid_q <= '0;
        end else if (key_clr_i) begin
            for (int i = 0; i < NumKeySlots; i++) key_q[i] <= '0;
            key_valid_q <= '0;
        end else if (key_wr_i) begin
            for (int i = 0; i < NumKeySlots; i++) begin
                if (SlotW'(i) == key_slot_i) begin
                    key_q[i]       <= key_i;
                    key_valid_q[i] <= 1'b1;
                end
            end
        end
    end

    assign key_valid_o = key_valid_q;

    // Select the request's key slot and fold it down to one datapath word; an out-of-range slot reads as invalid.
    always_comb begin
        sel_key   = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NumKeySlots; i++) begin
            if (SlotW'(i) == req_slot_i) begin
                sel_key   = key_q[i];
                sel_valid = key_valid_q[i];
            end
        end
        key_fold = '0;
        for (int w = 0; w < NumWords; w++) key_fold = key_fold ^ sel_key[w*Width +: Width];
        mask      = key_fold ^ lfsr_q;
        lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
    end

    // ALU on the unmasked operands; only meaningful in the final COMPUTE cycle.
    always_comb begin
        op_a  = a_q ^ mask_q;
        op_b  = b_q ^ mask_q;
        shamt = op_b[ShW-1:0];
        case (op_q)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SLTU: alu_res = {{(Width-1){1'b0}}, (op_a < op_b)};
            default: alu_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake outputs; flush overrides everything, including rsp_ready_i.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = sel_valid ? COMPUTE : RESP;
                end
            end
            COMPUTE: begin
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
        result_o = rsp_valid_o ? (res_q ^ mask_q) : '0;
        error_o  = rsp_valid_o & err_q;
    end

    // Masked datapath registers; scrubbed on flush and after the response is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LfsrSeed;
            mask_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_q   <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            mask_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_q   <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (sel_valid) begin
                            mask_q <= mask;
                            a_q    <= operand_a_i ^ mask;
                            b_q    <= operand_b_i ^ mask;
                            op_q   <= req_op_i;
                            cnt_q  <= CntW'(OpLatency - 1);
                            err_q  <= 1'b0;
                            res_q  <= '0;
                            lfsr_q <= lfsr_next;
                        end else begin
                            mask_q <= '0;
                            res_q  <= '0;
                            err_q  <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (cnt_q == '0) res_q <= alu_res ^ mask_q;
                    else             cnt_q <= cnt_q - 1'b1;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        mask_q <= '0;
                        a_q    <= '0;
                        b_q    <= '0;
                        res_q  <= '0;
                        op_q   <= '0;
                        err_q  <= 1'b0;
                        cnt_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
